// File: rtl/axis_ascon_tag_gate.sv
// Holds one decrypted message until its tag difference is known, then releases
// or discards it; emits one verdict beat per message.
module axis_ascon_tag_gate #(
    parameter int aw = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic         s_tlast,
    input  logic [127:0] s_tdata,
    input  logic [15:0]  s_tkeep,
    input  logic         s_tag_tvalid,
    output logic         s_tag_tready,
    input  logic [127:0] s_tag_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         m_tlast,
    output logic [127:0] m_tdata,
    output logic [15:0]  m_tkeep,
    output logic         m_status_tvalid,
    input  logic         m_status_tready,
    output logic [7:0]   m_status_tdata
);

    localparam int DEPTH = 2**aw;
    localparam logic [aw:0] DEPTH_C = (aw+1)'(DEPTH);
    localparam logic [aw:0] CNT_ONE = (aw+1)'(1);
    localparam logic [aw:0] CNT_TWO = (aw+1)'(2);

    typedef enum logic [1:0] {FILL, WAIT_TAG, RELEASE, STATUS} state_t;

    state_t state, state_nx;

    logic [143:0] mem [DEPTH];
    logic [143:0] rd_word;
    logic [aw:0]  wr_ptr, rd_ptr, count;
    logic         ovf, pass_q, empty_q;

    logic pay_hs, tag_hs, out_hs, st_hs;
    logic wr_en, ovf_set;
    logic verdict_pass, verdict_empty;

    assign pay_hs = s_tvalid && s_tready;
    assign tag_hs = s_tag_tvalid && s_tag_tready;
    assign out_hs = m_tvalid && m_tready;
    assign st_hs  = m_status_tvalid && m_status_tready;

    assign verdict_pass  = (s_tag_tdata == '0) && !ovf;
    assign verdict_empty = (count == '0);

    assign rd_word        = mem[rd_ptr[aw-1:0]];
    assign m_status_tdata = {5'b0, empty_q, ovf, pass_q};

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        ovf_set  = 1'b0;
        case (state)
            FILL: begin
                if (pay_hs) begin
                    // keep==0 beats are empty-message markers: consumed, never stored
                    if (s_tkeep != '0) begin
                        if (!ovf && count != DEPTH_C) wr_en = 1'b1;
                        else                          ovf_set = 1'b1;
                    end
                    if (s_tlast) state_nx = WAIT_TAG;
                end
            end
            WAIT_TAG: begin
                if (tag_hs) state_nx = (verdict_pass && !verdict_empty) ? RELEASE : STATUS;
            end
            RELEASE: begin
                if (out_hs && count == CNT_ONE) state_nx = STATUS;
            end
            STATUS: begin
                if (st_hs) state_nx = FILL;
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[aw-1:0]] <= {s_tdata, s_tkeep};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            ovf             <= 1'b0;
            pass_q          <= 1'b0;
            empty_q         <= 1'b0;
            s_tready        <= 1'b1;
            s_tag_tready    <= 1'b0;
            m_tvalid        <= 1'b0;
            m_tlast         <= 1'b0;
            m_tdata         <= '0;
            m_tkeep         <= '0;
            m_status_tvalid <= 1'b0;
        end else begin
            s_tready     <= (state_nx == FILL);
            s_tag_tready <= (state_nx == WAIT_TAG);

            if (wr_en) begin
                wr_ptr <= wr_ptr + CNT_ONE;
                count  <= count + CNT_ONE;
            end
            if (ovf_set) ovf <= 1'b1;

            case (state)
                WAIT_TAG: begin
                    if (tag_hs) begin
                        pass_q  <= verdict_pass;
                        empty_q <= verdict_empty;
                        if (verdict_pass && !verdict_empty) begin
                            m_tvalid          <= 1'b1;
                            {m_tdata, m_tkeep} <= rd_word;
                            m_tlast           <= (count == CNT_ONE);
                            rd_ptr            <= rd_ptr + CNT_ONE;
                        end else begin
                            wr_ptr          <= '0;
                            rd_ptr          <= '0;
                            count           <= '0;
                            m_status_tvalid <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    // output register is preloaded; count tracks beats not yet accepted
                    if (out_hs) begin
                        count <= count - CNT_ONE;
                        if (count == CNT_ONE) begin
                            m_tvalid        <= 1'b0;
                            m_tlast         <= 1'b0;
                            m_status_tvalid <= 1'b1;
                        end else begin
                            {m_tdata, m_tkeep} <= rd_word;
                            m_tlast            <= (count == CNT_TWO);
                            rd_ptr             <= rd_ptr + CNT_ONE;
                        end
                    end
                end
                STATUS: begin
                    if (st_hs) begin
                        m_status_tvalid <= 1'b0;
                        ovf             <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/axis_ascon_tag_gate.md
Name: axis_ascon_tag_gate

Overview:
- Sits directly downstream of axis_ascon_aead128 when it is run in decrypt mode.
- Consumes the decrypted payload stream and the decrypt tag-difference word, where a word of zero means the tag verified.
- Holds each message's plaintext in an internal buffer until the tag verdict is known.
- On a good tag it releases the whole message. On a bad tag or buffer overflow it discards the message. Either way it emits one status beat per message.

Parameters:
aw, 4, log2 of buffer depth in 128-bit beats (depth = 2**aw)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
s_tvalid  in  1  payload from cipher m_tvalid
s_tready  out  1  payload ready
s_tlast  in  1  last payload beat of message
s_tdata  in  128  decrypted payload
s_tkeep  in  16  byte enables; 0 allowed only with s_tlast (empty message marker)
s_tag_tvalid  in  1  tag-difference valid
s_tag_tready  out  1  tag-difference ready
s_tag_tdata  in  128  tag difference, 0 = authentic
m_tvalid  out  1  released plaintext valid
m_tready  in  1  released plaintext ready
m_tlast  out  1  last released beat
m_tdata  out  128  released plaintext
m_tkeep  out  16  released byte enables
m_status_tvalid  out  1  per-message verdict valid
m_status_tready  in  1  verdict ready
m_status_tdata  out  8  [0] pass, [1] overflow, [2] empty, [7:3] zero

Behaviour:
- Reset (async assert, sync release): state FILL, wr_ptr=rd_ptr=count=0, flags cleared.
- Reset drives s_tready=1, s_tag_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, m_status_tvalid=0.
- Reset mid-message loses the in-flight message, with no status.
- AXI-stream rules:
  - Outputs are registered.
  - Once valid is asserted, valid and data hold stable until the ready handshake.
- FILL (s_tready=1, s_tag_tready=0):
  - Each payload handshake with s_tkeep!=0 and count<depth writes {tdata,tkeep} at wr_ptr and increments wr_ptr and count.
  - A beat with s_tkeep==0 is consumed and not stored.
  - A storable beat arriving when count==depth sets ovf and is dropped. Beats after that are also dropped until tlast.
  - The s_tlast handshake moves to WAIT_TAG.
- WAIT_TAG (s_tready=0, s_tag_tready=1): on the tag handshake, evaluate the verdict.
  - pass = (tdata==0) && !ovf.
  - empty = (count==0).
  - If pass && !empty: go to RELEASE.
  - Otherwise: clear wr_ptr, rd_ptr and count (discard the message) and go to STATUS.
- RELEASE (both input readies 0):
  - Streams stored beats in order at 1 beat/clk when m_tready stays high.
  - The first m_tvalid is asserted the cycle after the tag handshake.
  - m_tlast=1 exactly on the beat where the remaining count==1, independent of the stored input tlast. This covers a trailing keep=0 marker.
  - After the last handshake: pointers equal, count=0, go to STATUS.
- STATUS (both input readies 0):
  - m_status_tvalid=1 with {5'b0, empty, ovf, pass}.
  - On the handshake: clear ovf, return to FILL.
  - s_tready rises the cycle after the status handshake.
- Only one message is in the block at a time. The cipher is back-pressured during WAIT_TAG, RELEASE and STATUS.
- Wrap-around: pointers are aw+1 bits and compare modulo 2**aw. The buffer drains fully each message, so wrap across messages is legal.
- Simultaneous events: none are possible between inputs and outputs, because the states are exclusive.
- Verdict rules:
  - A non-zero tag always yields pass=0.
  - Overflow yields pass=0 even when the tag is 0.
  - An empty message with a tag of 0 yields status 0x05.
- No plaintext byte is ever presented on m_* before its message's tag is checked.

Test Plan:
- 3 beats (keep 0xFFFF, 0xFFFF, 0x00FF), tag 0 -> 3 beats out in order, m_tlast on beat 3 with m_tkeep 0x00FF, then status 0x01.
- 2 beats, tag 0x...0001 -> no m_tvalid, status 0x00, next message accepted normally.
- aw=2, 5 full beats, tag 0 -> no payload out, status 0x02, buffer empty afterwards.
- Single beat keep 0x0000 tlast=1, tag 0 -> no payload, status 0x05; then 2 beats with tag 0 -> status 0x01.
- Release with m_tready toggling 1/0 every cycle, then m_status_tready held low 4 cycles -> m_tdata stable while stalled, status held, s_tready stays 0 until the status handshake.
- rst asserted mid-RELEASE after 1 of 4 beats -> m_tvalid drops immediately, s_tready=1 after release, a new message passes with status 0x01.
